// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: buffers host writes and replays them
// one at a time over the UART din/send/done handshake.
module uart_tx_fifo #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [0:7]    wdata,
  input  logic          wr,
  input  logic          clr_ovf,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic          idle,
  output logic [0:7]    tx_din,
  output logic          tx_send,
  input  logic          tx_done
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t          state_r;
  logic [0:7]      mem_r [DEPTH];
  logic [AW-1:0]   wptr_r;
  logic [AW-1:0]   rptr_r;
  logic            wr_ok_s;
  logic            drop_s;
  logic            pop_s;

  // Status flags come from the level counter only, never from pointer compares.
  assign full  = (level == FULL_LEVEL);
  assign empty = (level == (AW + 1)'(0));
  assign idle  = (state_r == ST_IDLE) & empty;

  // Per-cycle write/pop decisions.
  always_comb begin
    wr_ok_s = wr & ~full;
    drop_s  = wr & full;
    pop_s   = (state_r == ST_IDLE) & ~empty;
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (reset && wr_ok_s) begin
      mem_r[wptr_r] <= wdata;
    end
  end

  // Pointers, level, overflow flag and the send/gap sequencer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r  <= ST_IDLE;
      wptr_r   <= '0;
      rptr_r   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      tx_din   <= 8'h00;
      tx_send  <= 1'b0;
    end else begin
      if (wr_ok_s) begin
        wptr_r <= wptr_r + AW'(1);
      end

      case ({wr_ok_s, pop_s})
        2'b10:   level <= level + (AW + 1)'(1);
        2'b01:   level <= level - (AW + 1)'(1);
        default: level <= level;
      endcase

      // A dropped write beats a simultaneous clear.
      if (drop_s) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end

      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            tx_din  <= mem_r[rptr_r];
            rptr_r  <= rptr_r + AW'(1);
            tx_send <= 1'b1;
            state_r <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (tx_done) begin
            tx_send <= 1'b0;
            state_r <= ST_GAP;
          end
        end
        ST_GAP: begin
          tx_send <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          tx_send <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: vector table, directed corner sequences and a random
// run, all compared against a queue-based reference model.
module tb_uart_tx_fifo;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [0:7]    wdata;
  logic          wr;
  logic          clr_ovf;
  logic          full;
  logic          empty;
  logic [AW:0]   level;
  logic          overflow;
  logic          idle;
  logic [0:7]    tx_din;
  logic          tx_send;
  logic          tx_done;

  uart_tx_fifo #(.AW(AW)) dut (
    .clk(clk), .reset(reset), .wdata(wdata), .wr(wr), .clr_ovf(clr_ovf),
    .full(full), .empty(empty), .level(level), .overflow(overflow), .idle(idle),
    .tx_din(tx_din), .tx_send(tx_send), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: the queue holds bytes still waiting; m_send/m_gap describe
  // whether a frame is on the wire or in the mandatory post-frame pause.
  bit [7:0] q[$];
  bit       m_send, m_gap, m_ovf;
  bit [7:0] m_din;

  // UART responder bookkeeping
  int       age, low_cnt;
  bit       prev_send, seen;
  bit [7:0] got[$];
  int       lows[$];

  typedef struct {
    logic       rst_v;
    logic       w;
    logic [7:0] d;
    logic       c;
    logic       dn;
    logic       e_send;
    logic [7:0] e_din;
    int         e_level;
    logic       e_empty;
    logic       e_ovf;
    logic       e_idle;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic w, input logic [7:0] d,
                            input logic c, input logic dn);
    bit full_pre, can_pop;
    if (!r) begin
      q.delete();
      m_send = 1'b0; m_gap = 1'b0; m_ovf = 1'b0; m_din = 8'h00;
    end else begin
      full_pre = (q.size() == DEPTH);
      can_pop  = !m_send && !m_gap && (q.size() != 0);
      if (w && full_pre) m_ovf = 1'b1;
      else if (c)        m_ovf = 1'b0;
      if (m_send) begin
        if (dn) begin m_send = 1'b0; m_gap = 1'b1; end
      end else if (m_gap) begin
        m_gap = 1'b0;
      end else if (can_pop) begin
        m_din  = q.pop_front();
        m_send = 1'b1;
      end
      if (w && !full_pre) q.push_back(d);
    end
  endtask

  task automatic check_model();
    chk("m_send",  32'(tx_send),  32'(m_send));
    chk("m_din",   32'(tx_din),   32'(m_din));
    chk("m_level", 32'(level),    32'(q.size()));
    chk("m_full",  32'(full),     32'(q.size() == DEPTH));
    chk("m_empty", 32'(empty),    32'(q.size() == 0));
    chk("m_ovf",   32'(overflow), 32'(m_ovf));
    chk("m_idle",  32'(idle),     32'(!m_send && !m_gap && q.size() == 0));
  endtask

  task automatic cyc(input logic r, input logic w, input logic [7:0] d,
                     input logic c, input logic dn);
    reset = r; wr = w; wdata = d; clr_ovf = c; tx_done = dn;
    @(posedge clk);
    model_step(r, w, d, c, dn);
    #1;
    check_model();
  endtask

  task automatic uart_reset();
    age = 0; low_cnt = 0; prev_send = 1'b0; seen = 1'b0;
    got.delete(); lows.delete();
  endtask

  // One cycle with a behavioural UART: done fires once send has been high
  // for 'delay' cycles (delay 0 = never), or when forced.
  task automatic uart_cyc(input logic w, input logic [7:0] d, input logic c,
                          input int delay, input logic fdn);
    logic dn;
    if (tx_send) age++; else age = 0;
    if (tx_send && !prev_send) begin
      got.push_back(tx_din);
      if (seen) lows.push_back(low_cnt);
      seen = 1'b1;
    end
    if (tx_send) low_cnt = 0; else low_cnt++;
    prev_send = tx_send;
    dn = fdn | ((delay != 0) && tx_send && (age >= delay));
    cyc(1'b1, w, d, c, dn);
  endtask

  initial begin
    bit [7:0] exp_q[$];
    reset = 1'b0; wr = 1'b0; wdata = 8'h00; clr_ovf = 1'b0; tx_done = 1'b0;

    // rst_v w d c dn | send din level empty ovf idle (values after the edge)
    vecs[0]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 8'hA5, 1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, 1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, 1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h3C, 0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h3C, 0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h3C, 0, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h3C, 0, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h3C, 0, 1'b1, 1'b0, 1'b1};

    for (int i = 0; i < 12; i++) begin
      cyc(vecs[i].rst_v, vecs[i].w, vecs[i].d, vecs[i].c, vecs[i].dn);
      chk("vec_send",  32'(tx_send),  32'(vecs[i].e_send));
      chk("vec_din",   32'(tx_din),   32'(vecs[i].e_din));
      chk("vec_level", 32'(level),    32'(vecs[i].e_level));
      chk("vec_empty", 32'(empty),    32'(vecs[i].e_empty));
      chk("vec_ovf",   32'(overflow), 32'(vecs[i].e_ovf));
      chk("vec_idle",  32'(idle),     32'(vecs[i].e_idle));
    end

    // Single byte: write at cycle 0, done at cycle 20.
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int e = 0; e <= 21; e++) begin
      cyc(1'b1, (e == 0), 8'hA5, 1'b0, (e == 20));
      if (e == 1) begin
        chk("single_send1", 32'(tx_send), 32'd1);
        chk("single_din",   32'(tx_din),  32'hA5);
      end
      if (e == 20) chk("single_send20", 32'(tx_send), 32'd0);
      if (e == 21) begin
        chk("single_send21", 32'(tx_send), 32'd0);
        chk("single_idle21", 32'(idle),    32'd1);
      end
    end

    // Burst of three with a UART that finishes 10 cycles after send rises.
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    uart_reset();
    uart_cyc(1'b1, 8'h11, 1'b0, 10, 1'b0);
    chk("burst_lvl0", 32'(level), 32'd1);
    uart_cyc(1'b1, 8'h22, 1'b0, 10, 1'b0);
    chk("burst_lvl1", 32'(level), 32'd1);
    chk("burst_din1", 32'(tx_din), 32'h11);
    uart_cyc(1'b1, 8'h33, 1'b0, 10, 1'b0);
    chk("burst_lvl2", 32'(level), 32'd2);
    for (int i = 0; i < 60; i++) uart_cyc(1'b0, 8'h00, 1'b0, 10, 1'b0);
    chk("burst_nframes", 32'(got.size()), 32'd3);
    if (got.size() == 3) begin
      chk("burst_b0", 32'(got[0]), 32'h11);
      chk("burst_b1", 32'(got[1]), 32'h22);
      chk("burst_b2", 32'(got[2]), 32'h33);
    end
    chk("burst_ngaps", 32'(lows.size()), 32'd2);
    foreach (lows[i]) chk("burst_gap", 32'(lows[i]), 32'd2);
    chk("burst_end_lvl", 32'(level), 32'd0);

    // Fill to full with no done, overflow, drop during pop, clear-vs-set.
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    uart_reset();
    for (int i = 0; i < 17; i++) begin
      uart_cyc(1'b1, 8'(i + 1), 1'b0, 0, 1'b0);
      if (i == 15) begin
        chk("fill_lvl15", 32'(level), 32'd15);
        chk("fill_nfull", 32'(full),  32'd0);
      end
    end
    chk("fill_lvl16", 32'(level),    32'd16);
    chk("fill_full",  32'(full),     32'd1);
    chk("fill_ovf0",  32'(overflow), 32'd0);
    uart_cyc(1'b1, 8'hEE, 1'b0, 0, 1'b0);
    chk("drop_ovf",   32'(overflow), 32'd1);
    chk("drop_lvl",   32'(level),    32'd16);
    uart_cyc(1'b0, 8'h00, 1'b1, 0, 1'b0);
    chk("clr_ovf",    32'(overflow), 32'd0);
    uart_cyc(1'b0, 8'h00, 1'b0, 0, 1'b1);
    chk("gap_send",   32'(tx_send),  32'd0);
    uart_cyc(1'b0, 8'h00, 1'b0, 0, 1'b0);
    uart_cyc(1'b1, 8'hDD, 1'b0, 0, 1'b0);
    chk("pop_drop_ovf", 32'(overflow), 32'd1);
    chk("pop_drop_lvl", 32'(level),    32'd15);
    chk("pop_drop_din", 32'(tx_din),   32'h02);
    uart_cyc(1'b1, 8'h12, 1'b1, 0, 1'b0);
    chk("refill_ovf", 32'(overflow), 32'd0);
    chk("refill_lvl", 32'(level),    32'd16);
    uart_cyc(1'b1, 8'hEF, 1'b1, 0, 1'b0);
    chk("set_wins_ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < 300; i++) uart_cyc(1'b0, 8'h00, 1'b0, 3, 1'b0);
    for (int i = 1; i <= 17; i++) exp_q.push_back(8'(i));
    exp_q.push_back(8'h12);
    chk("drain_nframes", 32'(got.size()), 32'(exp_q.size()));
    if (got.size() == exp_q.size()) begin
      foreach (exp_q[i]) chk("drain_byte", 32'(got[i]), 32'(exp_q[i]));
    end
    foreach (lows[i]) chk("drain_gap", 32'(lows[i]), 32'd2);
    chk("drain_idle", 32'(idle), 32'd1);

    // Reset mid-frame with five bytes queued; a stale done must be ignored.
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    chk("mid_lvl5", 32'(level),   32'd5);
    chk("mid_send", 32'(tx_send), 32'd1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("rst_send",  32'(tx_send), 32'd0);
    chk("rst_lvl",   32'(level),   32'd0);
    chk("rst_empty", 32'(empty),   32'd1);
    chk("rst_idle",  32'(idle),    32'd1);
    chk("rst_din",   32'(tx_din),  32'h00);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      chk("stale_send", 32'(tx_send), 32'd0);
    end

    // Random traffic against the model, alternating heavy and light writers.
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      int wprob;
      wprob = ((i / 250) % 2 == 0) ? 85 : 15;
      cyc(($urandom_range(0, 299) != 0),
          ($urandom_range(0, 99) < wprob),
          8'($urandom),
          ($urandom_range(0, 99) < 5),
          ($urandom_range(0, 99) < 20));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
